cfg_bus_slave: RTL and testbench

Configuration-bus slave that sits directly upstream of the switch register block. It accepts single read/write transactions from the host-side configuration bus and decodes the register address. Writes become a one-cycle, one-hot write-enable pulse plus data toward the register block. Reads return the register block's current outputs through a handshaked, optionally wait-stated access.

---
 rtl/cfg_pkg.sv | 19 +
 rtl/cfg_bus_slave_if.sv | 23 ++
 rtl/cfg_addr_decode.sv | 30 +++
 rtl/cfg_bus_slave.sv | 123 ++++++++++++
 tb/tb_cfg_bus_slave.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared constants and FSM state type for the configuration bus slave
package cfg_pkg;

  // Register byte addresses as seen by the host
  localparam logic [7:0] CFG_ADDR_REG0 = 8'h00;
  localparam logic [7:0] CFG_ADDR_REG1 = 8'h02;
  localparam logic [7:0] CFG_ADDR_REG2 = 8'h04;
  localparam logic [7:0] CFG_ADDR_REG3 = 8'h08;

  // Largest wait-state count the 4-bit access counter can hold
  localparam int CFG_MAX_WAIT = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/cfg_bus_slave_if.sv
// rtl/cfg_bus_slave_if.sv - host-side configuration bus request/response signals
interface cfg_bus_slave_if;

  logic       cfg_sel;
  logic       cfg_wr;
  logic [7:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       cfg_ready;
  logic       cfg_ack;
  logic       cfg_err;
  logic [7:0] cfg_rdata;

  modport master (
    output cfg_sel, cfg_wr, cfg_addr, cfg_wdata,
    input  cfg_ready, cfg_ack, cfg_err, cfg_rdata
  );

  modport slave (
    input  cfg_sel, cfg_wr, cfg_addr, cfg_wdata,
    output cfg_ready, cfg_ack, cfg_err, cfg_rdata
  );

endinterface

// File: rtl/cfg_addr_decode.sv
// rtl/cfg_addr_decode.sv - maps a register byte address to index, one-hot strobe and hit flag
module cfg_addr_decode
  import cfg_pkg::*;
#(
  parameter int NUM_OF_REG = 4
) (
  input  logic [7:0] addr,
  output logic [1:0] index,
  output logic [7:0] onehot,
  output logic       valid
);

  logic hit;

  // Exact-match decode; indices beyond the populated register count are unmapped
  always_comb begin
    index = 2'd0;
    hit   = 1'b0;
    case (addr)
      CFG_ADDR_REG0: begin index = 2'd0; hit = 1'b1; end
      CFG_ADDR_REG1: begin index = 2'd1; hit = 1'b1; end
      CFG_ADDR_REG2: begin index = 2'd2; hit = 1'b1; end
      CFG_ADDR_REG3: begin index = 2'd3; hit = 1'b1; end
      default:       begin index = 2'd0; hit = 1'b0; end
    endcase
    valid  = hit && (int'(index) < NUM_OF_REG);
    onehot = valid ? (8'd1 << index) : 8'd0;
  end

endmodule

// File: rtl/cfg_bus_slave.sv
// rtl/cfg_bus_slave.sv - configuration bus slave driving write strobes and read-back of the register block
module cfg_bus_slave
  import cfg_pkg::*;
#(
  parameter int NUM_OF_REG  = 4,
  parameter int WAIT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  cfg_bus_slave_if.slave   bus,
  output logic [7:0]       wr_en,
  output logic [7:0]       wr_data,
  input  logic [7:0]       reg_data_in_0,
  input  logic [7:0]       reg_data_in_1,
  input  logic [7:0]       reg_data_in_2,
  input  logic [7:0]       reg_data_in_3
);

  localparam logic [3:0] WAIT_LOAD =
    4'((WAIT_CYCLES > CFG_MAX_WAIT) ? CFG_MAX_WAIT : WAIT_CYCLES);

  cfg_state_e state, next_state;
  logic [3:0] cnt;
  logic       cap_wr;
  logic [7:0] cap_addr;
  logic [7:0] cap_wdata;

  logic       accept;
  logic       last_access;
  logic       strobe_arm;
  logic [7:0] strobe_data;
  logic [7:0] dec_addr;
  logic [1:0] dec_index;
  logic [7:0] dec_onehot;
  logic       dec_valid;
  logic [7:0] rd_mux;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode: one request per IDLE visit, fixed ACCESS length, single RESP cycle
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.cfg_sel) next_state = ACCESS;
      ACCESS:  if (cnt == 4'd0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign bus.cfg_ready = (state == IDLE);

  // Request capture and wait-state counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 4'd0;
      cap_wr    <= 1'b0;
      cap_addr  <= 8'h00;
      cap_wdata <= 8'h00;
    end else if (accept) begin
      cnt       <= WAIT_LOAD;
      cap_wr    <= bus.cfg_wr;
      cap_addr  <= bus.cfg_addr;
      cap_wdata <= bus.cfg_wdata;
    end else if (state == ACCESS && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // The strobe is registered one edge ahead of the last ACCESS cycle; with no wait
  // states that edge is the accept edge, so the decoder looks at the live bus address in IDLE
  always_comb begin
    accept      = (state == IDLE) && bus.cfg_sel;
    last_access = (state == ACCESS) && (cnt == 4'd0);
    dec_addr    = (state == IDLE) ? bus.cfg_addr  : cap_addr;
    strobe_data = (state == IDLE) ? bus.cfg_wdata : cap_wdata;
    strobe_arm  = (accept && bus.cfg_wr && (WAIT_LOAD == 4'd0)) ||
                  ((state == ACCESS) && (cnt == 4'd1) && cap_wr);
  end

  cfg_addr_decode #(
    .NUM_OF_REG (NUM_OF_REG)
  ) u_decode (
    .addr   (dec_addr),
    .index  (dec_index),
    .onehot (dec_onehot),
    .valid  (dec_valid)
  );

  // Read-back mux over the register block outputs
  always_comb begin
    rd_mux = 8'h00;
    case (dec_index)
      2'd0: rd_mux = reg_data_in_0;
      2'd1: rd_mux = reg_data_in_1;
      2'd2: rd_mux = reg_data_in_2;
      2'd3: rd_mux = reg_data_in_3;
      default: rd_mux = 8'h00;
    endcase
  end

  // Registered outputs: write strobe, response pulse, error flag and held read data
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en         <= 8'h00;
      wr_data       <= 8'h00;
      bus.cfg_ack   <= 1'b0;
      bus.cfg_err   <= 1'b0;
      bus.cfg_rdata <= 8'h00;
    end else begin
      wr_en <= strobe_arm ? dec_onehot : 8'h00;
      if (strobe_arm && dec_valid) wr_data <= strobe_data;
      bus.cfg_ack <= last_access;
      bus.cfg_err <= last_access && !dec_valid;
      if (last_access && !cap_wr) bus.cfg_rdata <= dec_valid ? rd_mux : 8'h00;
    end
  end

endmodule

// File: tb/tb_cfg_bus_slave.sv
// tb/tb_cfg_bus_slave.sv - self-checking bench for cfg_bus_slave across three configurations
module tb_cfg_bus_slave;

  typedef struct {
    bit         err;
    bit         is_rd;
    logic [7:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   vec  = 0;
  int   errs = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel_a = 1'b0, sel_b = 1'b0, sel_c = 1'b0;
  logic       t_wr = 1'b0;
  logic [7:0] t_addr = 8'h00, t_wdata = 8'h00;
  int         pick = 0;

  logic [7:0] wr_en_a, wr_data_a, wr_en_b, wr_data_b, wr_en_c, wr_data_c;
  logic [7:0] regs_a [4];

  logic       o_ready, o_ack, o_err;
  logic [7:0] o_rdata, o_wr_en, o_wr_data;

  always #5 clk = ~clk;

  cfg_bus_slave_if bus_a ();
  cfg_bus_slave_if bus_b ();
  cfg_bus_slave_if bus_c ();

  assign bus_a.cfg_sel = sel_a;  assign bus_a.cfg_wr = t_wr;
  assign bus_a.cfg_addr = t_addr; assign bus_a.cfg_wdata = t_wdata;
  assign bus_b.cfg_sel = sel_b;  assign bus_b.cfg_wr = t_wr;
  assign bus_b.cfg_addr = t_addr; assign bus_b.cfg_wdata = t_wdata;
  assign bus_c.cfg_sel = sel_c;  assign bus_c.cfg_wr = t_wr;
  assign bus_c.cfg_addr = t_addr; assign bus_c.cfg_wdata = t_wdata;

  // Instance A: default configuration backed by a small register block
  cfg_bus_slave #(.NUM_OF_REG(4), .WAIT_CYCLES(0)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .wr_en(wr_en_a), .wr_data(wr_data_a),
    .reg_data_in_0(regs_a[0]), .reg_data_in_1(regs_a[1]),
    .reg_data_in_2(regs_a[2]), .reg_data_in_3(regs_a[3])
  );

  // Instance B: only three registers populated
  cfg_bus_slave #(.NUM_OF_REG(3), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .wr_en(wr_en_b), .wr_data(wr_data_b),
    .reg_data_in_0(8'h5A), .reg_data_in_1(8'h11),
    .reg_data_in_2(8'h22), .reg_data_in_3(8'h77)
  );

  // Instance C: three wait states
  cfg_bus_slave #(.NUM_OF_REG(4), .WAIT_CYCLES(3)) dut_c (
    .clk(clk), .rst(rst), .bus(bus_c), .wr_en(wr_en_c), .wr_data(wr_data_c),
    .reg_data_in_0(8'hC0), .reg_data_in_1(8'hC1),
    .reg_data_in_2(8'hC2), .reg_data_in_3(8'hC3)
  );

  // Register block for instance A: captures on the write strobe
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst)             regs_a[i] <= 8'h00;
      else if (wr_en_a[i]) regs_a[i] <= wr_data_a;
    end
  end

  // Observation port for whichever instance is under test
  always_comb begin
    case (pick)
      0: begin o_ready = bus_a.cfg_ready; o_ack = bus_a.cfg_ack; o_err = bus_a.cfg_err;
               o_rdata = bus_a.cfg_rdata; o_wr_en = wr_en_a; o_wr_data = wr_data_a; end
      1: begin o_ready = bus_b.cfg_ready; o_ack = bus_b.cfg_ack; o_err = bus_b.cfg_err;
               o_rdata = bus_b.cfg_rdata; o_wr_en = wr_en_b; o_wr_data = wr_data_b; end
      default: begin o_ready = bus_c.cfg_ready; o_ack = bus_c.cfg_ack; o_err = bus_c.cfg_err;
               o_rdata = bus_c.cfg_rdata; o_wr_en = wr_en_c; o_wr_data = wr_data_c; end
    endcase
  end

  task automatic test_reset(input int p);
    pick = p;
    #1;
    vec++; if (o_ready !== 1'b1) begin errs++; $display("FAIL reset ready: got %b want 1", o_ready); end
    vec++; if (o_ack !== 1'b0 || o_err !== 1'b0) begin errs++; $display("FAIL reset ack/err: got %b/%b want 0/0", o_ack, o_err); end
    vec++; if (o_rdata !== 8'h00) begin errs++; $display("FAIL reset rdata: got %h want 00", o_rdata); end
    vec++; if (o_wr_en !== 8'h00 || o_wr_data !== 8'h00) begin errs++; $display("FAIL reset wr_en/wr_data: got %h/%h want 00/00", o_wr_en, o_wr_data); end
  endtask

  // One zero-wait transaction on instance A or B, entered and left at a negedge in IDLE
  task automatic txn0(input int p, input bit wr, input logic [7:0] addr, input logic [7:0] wd,
                      input logic [7:0] exp_en, input bit exp_err, input logic [7:0] exp_rd);
    exp_t e;
    pick = p; t_wr = wr; t_addr = addr; t_wdata = wd;
    exp_q.push_back('{exp_err, !wr, exp_rd});
    if (p == 0) sel_a = 1'b1; else sel_b = 1'b1;
    #1;
    vec++; if (o_ready !== 1'b1) begin errs++; $display("FAIL txn ready c0 @%h: got %b want 1", addr, o_ready); end
    @(negedge clk);
    sel_a = 1'b0; sel_b = 1'b0;
    vec++; if (o_wr_en !== exp_en) begin errs++; $display("FAIL txn wr_en c1 @%h: got %h want %h", addr, o_wr_en, exp_en); end
    if (exp_en != 8'h00) begin
      vec++; if (o_wr_data !== wd) begin errs++; $display("FAIL txn wr_data c1 @%h: got %h want %h", addr, o_wr_data, wd); end
    end
    vec++; if (o_ready !== 1'b0 || o_ack !== 1'b0) begin errs++; $display("FAIL txn ready/ack c1 @%h: got %b/%b want 0/0", addr, o_ready, o_ack); end
    @(negedge clk);
    vec++; if (o_wr_en !== 8'h00) begin errs++; $display("FAIL txn wr_en c2 @%h: got %h want 00", addr, o_wr_en); end
    vec++; if (o_ack !== 1'b1) begin errs++; $display("FAIL txn ack c2 @%h: got %b want 1", addr, o_ack); end
    if (o_ack === 1'b1) begin
      vec++;
      if (exp_q.size() == 0) begin errs++; $display("FAIL txn scoreboard @%h: got ack want none pending", addr); end
      else begin
        e = exp_q.pop_front();
        if (o_err !== e.err) begin errs++; $display("FAIL txn err @%h: got %b want %b", addr, o_err, e.err); end
        if (e.is_rd) begin
          vec++; if (o_rdata !== e.rdata) begin errs++; $display("FAIL txn rdata @%h: got %h want %h", addr, o_rdata, e.rdata); end
        end
      end
    end
    @(negedge clk);
    vec++; if (o_ready !== 1'b1 || o_ack !== 1'b0) begin errs++; $display("FAIL txn ready/ack c3 @%h: got %b/%b want 1/0", addr, o_ready, o_ack); end
  endtask

  task automatic test_write_readback;
    txn0(0, 1'b1, 8'h04, 8'hA5, 8'h04, 1'b0, 8'h00);
    txn0(0, 1'b0, 8'h04, 8'h00, 8'h00, 1'b0, 8'hA5);
  endtask

  task automatic test_read_hold;
    txn0(0, 1'b1, 8'h08, 8'h3C, 8'h08, 1'b0, 8'h00);
    txn0(0, 1'b0, 8'h08, 8'h00, 8'h00, 1'b0, 8'h3C);
    repeat (2) @(negedge clk);
    vec++; if (o_rdata !== 8'h3C) begin errs++; $display("FAIL hold idle rdata: got %h want 3C", o_rdata); end
    txn0(0, 1'b1, 8'h00, 8'h99, 8'h01, 1'b0, 8'h00);
    vec++; if (o_rdata !== 8'h3C) begin errs++; $display("FAIL hold after write rdata: got %h want 3C", o_rdata); end
    txn0(0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h99);
  endtask

  task automatic test_unmapped;
    txn0(1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h5A);
    txn0(1, 1'b1, 8'h06, 8'hEE, 8'h00, 1'b1, 8'h00);
    txn0(1, 1'b1, 8'h08, 8'hEE, 8'h00, 1'b1, 8'h00);
    txn0(1, 1'b0, 8'h08, 8'h00, 8'h00, 1'b1, 8'h00);
    txn0(0, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b1, 8'h00);
  endtask

  task automatic test_wait_states;
    exp_t e;
    int   stray;
    pick = 2; t_wr = 1'b1; t_addr = 8'h00; t_wdata = 8'h11; sel_c = 1'b1;
    exp_q.push_back('{1'b0, 1'b0, 8'h00});
    @(negedge clk);
    for (int c = 1; c <= 6; c++) begin
      vec++; if (o_wr_en !== ((c == 4) ? 8'h01 : 8'h00)) begin errs++; $display("FAIL wait wr_en c%0d: got %h want %h", c, o_wr_en, (c == 4) ? 8'h01 : 8'h00); end
      vec++; if (o_ack !== (c == 5)) begin errs++; $display("FAIL wait ack c%0d: got %b want %b", c, o_ack, (c == 5)); end
      vec++; if (o_ready !== (c == 6)) begin errs++; $display("FAIL wait ready c%0d: got %b want %b", c, o_ready, (c == 6)); end
      if (c == 4) begin
        vec++; if (o_wr_data !== 8'h11) begin errs++; $display("FAIL wait wr_data: got %h want 11", o_wr_data); end
      end
      if (c == 5 && o_ack === 1'b1) begin
        vec++;
        if (exp_q.size() == 0) begin errs++; $display("FAIL wait scoreboard: got ack want none pending"); end
        else begin
          e = exp_q.pop_front();
          if (o_err !== e.err) begin errs++; $display("FAIL wait err: got %b want %b", o_err, e.err); end
        end
      end
      if (c <= 3) begin sel_c = ~sel_c; t_addr = 8'h02; t_wdata = 8'hEE; end
      else sel_c = 1'b0;
      @(negedge clk);
    end
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      if (o_ack !== 1'b0 || o_wr_en !== 8'h00) stray++;
      @(negedge clk);
    end
    vec++; if (stray != 0) begin errs++; $display("FAIL wait stray activity: got %0d cycles want 0", stray); end
  endtask

  task automatic test_back_to_back;
    exp_t       e;
    logic [7:0] exp_en;
    int         pulses;
    pick = 0; t_wr = 1'b1; t_addr = 8'h00; t_wdata = 8'h21; sel_a = 1'b1;
    exp_q.push_back('{1'b0, 1'b0, 8'h00});
    exp_q.push_back('{1'b0, 1'b0, 8'h00});
    pulses = 0;
    @(negedge clk);
    for (int c = 1; c <= 8; c++) begin
      exp_en = (c == 1) ? 8'h01 : (c == 4) ? 8'h02 : 8'h00;
      if (o_wr_en !== 8'h00) pulses++;
      vec++; if (o_wr_en !== exp_en) begin errs++; $display("FAIL b2b wr_en c%0d: got %h want %h", c, o_wr_en, exp_en); end
      vec++; if (o_ack !== (c == 2 || c == 5)) begin errs++; $display("FAIL b2b ack c%0d: got %b want %b", c, o_ack, (c == 2 || c == 5)); end
      if (c == 1 || c == 4) begin
        vec++; if (o_wr_data !== ((c == 1) ? 8'h21 : 8'h42)) begin errs++; $display("FAIL b2b wr_data c%0d: got %h want %h", c, o_wr_data, (c == 1) ? 8'h21 : 8'h42); end
      end
      if (o_ack === 1'b1) begin
        vec++;
        if (exp_q.size() == 0) begin errs++; $display("FAIL b2b scoreboard c%0d: got ack want none pending", c); end
        else begin
          e = exp_q.pop_front();
          if (o_err !== e.err) begin errs++; $display("FAIL b2b err c%0d: got %b want %b", c, o_err, e.err); end
        end
      end
      if (c == 1) begin t_addr = 8'h02; t_wdata = 8'h42; end
      if (c == 4) sel_a = 1'b0;
      @(negedge clk);
    end
    vec++; if (pulses != 2) begin errs++; $display("FAIL b2b pulse count: got %0d want 2", pulses); end
    vec++; if (regs_a[1] !== 8'h42 || regs_a[0] !== 8'h21) begin errs++; $display("FAIL b2b regs: got %h/%h want 21/42", regs_a[0], regs_a[1]); end
  endtask

  task automatic test_reset_mid;
    int stray;
    pick = 2; t_wr = 1'b1; t_addr = 8'h02; t_wdata = 8'h5A; sel_c = 1'b1;
    @(negedge clk);
    sel_c = 1'b0;
    vec++; if (o_ready !== 1'b0) begin errs++; $display("FAIL rstmid in access ready: got %b want 0", o_ready); end
    rst = 1'b1;
    @(negedge clk);
    test_reset(2);
    rst = 1'b0;
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (o_ack !== 1'b0 || o_wr_en !== 8'h00 || o_ready !== 1'b1) stray++;
    end
    vec++; if (stray != 0) begin errs++; $display("FAIL rstmid aborted activity: got %0d cycles want 0", stray); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset(0);
    test_reset(2);
    rst = 1'b0;
    @(negedge clk);
    test_write_readback;
    test_read_hold;
    test_unmapped;
    test_wait_states;
    test_back_to_back;
    test_reset_mid;
    vec++; if (exp_q.size() != 0) begin errs++; $display("FAIL scoreboard leftover: got %0d want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
